if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the pipelined MIPS-Lite core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. Fetched words, each paired with its PC+4, are presented on a registered output that feeds the IF/ID pipeline register. It honours stall from the hazard unit and redirect (branch/jump flush) from later stages, with a 1-entry skid buffer so no response is lost while stalled.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold outputs, no new request issued (hazard unit)
- redirect  in  1  flush and load redirect_pc (priority over stall)
- redirect_pc  in  32  branch/jump target
- imem_req  out  1  read request, held until ack
- imem_addr  out  32  read address, stable while imem_req=1
- imem_ack  in  1  response valid; may coincide with first req cycle (zero-wait)
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- pc_out  out  32  fetch address + 4 of ins_out
- ins_out  out  32  fetched instruction; 0 (NOP) when bubble
- valid_out  out  1  ins_out is a real instruction
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: IDLE, FETCH, DISCARD, FULL. Reset state IDLE; IDLE -> FETCH unconditionally next cycle.
- Registers: pc (next address), req_addr (outstanding address), skid {pc,ins}, output {pc_out,ins_out,valid_out}.
- imem_req=1 in FETCH and DISCARD only; imem_addr=req_addr.
- Entering FETCH or firing a new request: req_addr<=pc.
- FETCH, ack, !stall: output<={req_addr+4, rdata, 1}; pc<=pc+4; next request at pc+4; stay FETCH.
- FETCH, ack, stall: skid<={req_addr+4, rdata}; pc<=pc+4; -> FULL; output held.
- FETCH, no ack, !stall: output<={pc_out, 0, 0} (bubble); stall: output held.
- FULL: imem_req=0; when !stall: output<=skid with valid=1, skid emptied, -> FETCH.
- Redirect (any state): pc<=target; output<={pc_out, 0, 0} even if stall; skid emptied.
  - FETCH without ack -> DISCARD (request completes at old req_addr, response dropped).
  - FETCH with ack same cycle -> response dropped, -> FETCH at target.
  - FULL -> FETCH at target. DISCARD -> stays DISCARD, pc updated (last redirect wins).
- DISCARD, ack: response dropped, -> FETCH with req_addr<=pc.
- Target alignment: redirect_pc[1:0] forced to 2'b00 before loading pc.
- pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0, no flag.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc_out=0, ins_out=0, valid_out=0, misalign_err=0, skid empty, state IDLE.
- First request asserted in the cycle after rst deasserts.
- Latency: ack sampled at edge N -> ins_out/valid_out updated at edge N.
- Zero-wait memory, no stall: one instruction per cycle, valid_out continuously 1 after first ack.
- Wait-state memory: one bubble per extra cycle.
- Stall asserted: at most one response absorbed (skid); no further request until drained.
- Reset mid-request: state and outputs return to reset values immediately; the outstanding ack is ignored because imem_req drops.

## Configuration
- IF_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err at that edge; it stays 1 until rst.
- Undefined: misalign_err tied 0; low-bit clearing still applied.

## Test plan
- Reset, RESET_PC=0, ack tied 1 -> addrs 0,4,8 on successive cycles; pc_out 4,8,12 with valid_out=1.
- Ack 2 cycles after each req -> valid_out pattern 0,0,1 repeating; ins_out=0 in bubbles.
- Stall high 3 cycles while ack arrives -> outputs frozen, imem_req=0 after capture; on release skid word appears next edge, no word lost or duplicated.
- Redirect to 32'h100 while request to 8 pending -> ack for 8 dropped, valid_out=0, next imem_addr=32'h100, pc_out=32'h104.
- Redirect with stall=1 and skid full -> skid dropped, ins_out=0/valid_out=0, fetch resumes at target.
- IF_ALIGN_CHECK_EN, redirect_pc=32'h202 -> fetch at 32'h200, misalign_err=1 until rst; without macro it stays 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS-Lite instruction fetch with req/ack imem port, 1-entry skid buffer and redirect flush.
// Optional IF_ALIGN_CHECK_EN makes misalign_err a sticky flag for misaligned redirect targets.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        valid_out,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, FULL} state_t;
    state_t      state_q;
    logic [31:0] pc_q, req_addr_q, skid_pc_q, skid_ins_q, pc_out_q, ins_out_q;
    logic        valid_q;
    logic [31:0] tgt, pc_inc, req_inc;
    assign tgt       = redirect_pc & ~32'h3;
    assign pc_inc    = pc_q + 32'd4;
    assign req_inc   = req_addr_q + 32'd4;
    assign imem_req  = (state_q == FETCH) || (state_q == DISCARD);
    assign imem_addr = req_addr_q;
    assign pc_out    = pc_out_q;
    assign ins_out   = ins_out_q;
    assign valid_out = valid_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            skid_pc_q  <= '0;
            skid_ins_q <= '0;
            pc_out_q   <= '0;
            ins_out_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            // A redirect always flushes the output, even under stall
            if (redirect) begin
                pc_q      <= tgt;
                ins_out_q <= '0;
                valid_q   <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    req_addr_q <= redirect ? tgt : pc_q;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ack) req_addr_q <= tgt;
                        else state_q <= DISCARD;
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                        if (stall) begin
                            skid_pc_q  <= req_inc;
                            skid_ins_q <= imem_rdata;
                            state_q    <= FULL;
                        end else begin
                            pc_out_q   <= req_inc;
                            ins_out_q  <= imem_rdata;
                            valid_q    <= 1'b1;
                            req_addr_q <= pc_inc;
                        end
                    end else if (!stall) begin
                        ins_out_q <= '0;
                        valid_q   <= 1'b0;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_q    <= FETCH;
                        req_addr_q <= redirect ? tgt : pc_q;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        state_q    <= FETCH;
                        req_addr_q <= tgt;
                    end else if (!stall) begin
                        pc_out_q   <= skid_pc_q;
                        ins_out_q  <= skid_ins_q;
                        valid_q    <= 1'b1;
                        state_q    <= FETCH;
                        req_addr_q <= pc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef IF_ALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else if (redirect && |redirect_pc[1:0]) misalign_q <= 1'b1;
    end
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch, wait states, stall/skid, redirect, alignment and reset.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_ack, imem_req, valid_out, misalign_err;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, pc_out, ins_out;
    int          total = 0;
    int          bad = 0;
    logic        mis_exp;
    if_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .ins_out(ins_out), .valid_out(valid_out), .misalign_err(misalign_err)
    );
    always #5 clk = ~clk;
    assign imem_rdata = ~imem_addr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic out_chk(input string tag, input logic [31:0] p, input logic [31:0] i, input logic v);
        chk({tag, ".pc"}, pc_out, p);
        chk({tag, ".ins"}, ins_out, i);
        chk({tag, ".vld"}, {31'b0, valid_out}, {31'b0, v});
    endtask
    task automatic req_chk(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, r});
        if (r) chk({tag, ".addr"}, imem_addr, a);
    endtask
    initial begin
`ifdef IF_ALIGN_CHECK_EN
        mis_exp = 1'b1;
`else
        mis_exp = 1'b0;
`endif
        rst = 1; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0;
        tick(); tick();
        req_chk("rst", 1'b0, 32'h0);
        chk("rst.addr", imem_addr, 32'h0);
        out_chk("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.mis", {31'b0, misalign_err}, 32'h0);
        rst = 0;
        tick();
        req_chk("first", 1'b1, 32'h0);
        imem_ack = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            out_chk("zw", 32'(4 * k), ~32'(4 * (k - 1)), 1'b1);
            req_chk("zw", 1'b1, 32'(4 * k));
        end
        for (int r = 0; r < 2; r++) begin
            imem_ack = 0;
            tick(); out_chk("ws0", 32'(12 + 4 * r), 32'h0, 1'b0);
            tick(); out_chk("ws1", 32'(12 + 4 * r), 32'h0, 1'b0);
            req_chk("ws", 1'b1, 32'(12 + 4 * r));
            imem_ack = 1;
            tick(); out_chk("ws2", 32'(16 + 4 * r), ~32'(12 + 4 * r), 1'b1);
        end
        stall = 1; imem_ack = 1;
        tick(); out_chk("stall0", 32'd20, ~32'd16, 1'b1); req_chk("stall0", 1'b0, 32'h0);
        imem_ack = 0;
        tick(); out_chk("stall1", 32'd20, ~32'd16, 1'b1); req_chk("stall1", 1'b0, 32'h0);
        tick(); out_chk("stall2", 32'd20, ~32'd16, 1'b1);
        stall = 0;
        tick(); out_chk("drain", 32'd24, ~32'd20, 1'b1); req_chk("drain", 1'b1, 32'd24);
        imem_ack = 1;
        tick(); out_chk("after", 32'd28, ~32'd24, 1'b1);
        imem_ack = 0; redirect = 1; redirect_pc = 32'h100;
        tick(); out_chk("rd0", 32'd28, 32'h0, 1'b0); req_chk("rd0", 1'b1, 32'd28);
        redirect = 0; imem_ack = 1;
        tick(); out_chk("rd1", 32'd28, 32'h0, 1'b0); req_chk("rd1", 1'b1, 32'h100);
        tick(); out_chk("rd2", 32'h104, ~32'h100, 1'b1);
        stall = 1;
        tick(); out_chk("sk0", 32'h104, ~32'h100, 1'b1); req_chk("sk0", 1'b0, 32'h0);
        redirect = 1; redirect_pc = 32'h200; imem_ack = 0;
        tick(); out_chk("sk1", 32'h104, 32'h0, 1'b0); req_chk("sk1", 1'b1, 32'h200);
        redirect = 0; stall = 0; imem_ack = 1;
        tick(); out_chk("sk2", 32'h204, ~32'h200, 1'b1);
        redirect = 1; redirect_pc = 32'h302;
        tick(); out_chk("al0", 32'h204, 32'h0, 1'b0); req_chk("al0", 1'b1, 32'h300);
        chk("al.mis", {31'b0, misalign_err}, {31'b0, mis_exp});
        redirect = 0;
        tick(); out_chk("al1", 32'h304, ~32'h300, 1'b1);
        chk("al.sticky", {31'b0, misalign_err}, {31'b0, mis_exp});
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick(); req_chk("wr0", 1'b1, 32'hFFFF_FFFC);
        redirect = 0;
        tick(); out_chk("wr1", 32'h0, 32'h3, 1'b1); req_chk("wr1", 1'b1, 32'h0);
        chk("wr.mis", {31'b0, misalign_err}, {31'b0, mis_exp});
        imem_ack = 0;
        @(negedge clk);
        rst = 1;
        #1;
        req_chk("mrst", 1'b0, 32'h0);
        chk("mrst.addr", imem_addr, 32'h0);
        out_chk("mrst", 32'h0, 32'h0, 1'b0);
        chk("mrst.mis", {31'b0, misalign_err}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
